mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Request sequencer that sits directly upstream of the 8x8 memory module and drives its address, data, op and select pins. Host read/write requests are accepted over a valid/ready handshake into a small request FIFO. A state machine replays each request as a timed SETUP/ACCESS/DONE select pulse on the memory pins. Read data is captured from the memory's OR-combined outputs and returned over a valid/ready response channel.

Parameters:
FIFO_DEPTH, 4, request FIFO entries; power of 2, minimum 2
ACCESS_CYCLES, 2, cycles mem_select is held high per access; minimum 1

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
req_valid  input  1  host request valid
req_ready  output  1  controller can accept a request
req_we  input  1  1 = write, 0 = read
req_adr  input  3  target word address 0..7
req_wdata  input  8  write data
rsp_valid  output  1  read data valid
rsp_ready  input  1  host accepts read data
rsp_rdata  output  8  read data
wr_done  output  1  one-cycle pulse when a write completes
busy  output  1  FSM not in IDLE, or FIFO non-empty
err_verify  output  1  sticky write-verify mismatch; tied 0 when feature is off
mem_adr  output  3  to memory adr2..adr0
mem_wdata  output  8  to memory i7..i0
mem_op  output  1  to memory op; 1 = write, 0 = read
mem_select  output  1  to memory select
mem_rdata  input  8  from memory o7..o0

Behaviour:
- Clock is i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset, applied asynchronously at any time including mid-access: every output goes to 0, the FIFO is emptied (pointers and count = 0), the FSM goes to IDLE, and err_verify is cleared. mem_select must drop in the same instant reset asserts.
- FIFO entry is {we, adr[2:0], wdata[7:0]}, 12 bits wide.
- req_ready = !full. It depends only on the registered count; there is no pass-through.
- A push occurs on req_valid && req_ready.
- Push and pop in the same cycle leave the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, ACCESS, DONE (plus VSETUP and VACCESS when the optional feature is compiled in).
- IDLE: if the FIFO is non-empty, pop the head into the command register and go to SETUP.
- SETUP (1 cycle): drive mem_adr, mem_op and mem_wdata from the command register, with mem_select = 0. This gives setup time before select rises.
- ACCESS (ACCESS_CYCLES cycles, counted by a down-counter): mem_select = 1, with address, op and data held stable. For a read, mem_rdata is registered into rsp_rdata on the last ACCESS cycle.
- DONE: mem_select = 0 and mem_op = 0.
  - Write: pulse wr_done for 1 cycle, then go to IDLE.
  - Read: assert rsp_valid. Hold rsp_valid and rsp_rdata stable until rsp_ready; the FSM stays in DONE while rsp_valid && !rsp_ready. On the handshake, clear rsp_valid and go to IDLE.
- mem_adr and mem_wdata hold their last value in IDLE. mem_op is 0 whenever mem_select is 0 outside SETUP.
- Latency: for a request accepted at edge 0 into an empty FIFO with the FSM in IDLE:
  - pop at edge 1
  - SETUP at cycle 2
  - ACCESS for cycles 3..2+ACCESS_CYCLES
  - rsp_valid / wr_done at cycle 3+ACCESS_CYCLES (cycle 5 with defaults)
- Back-to-back requests: each access takes 3+ACCESS_CYCLES cycles, with one IDLE cycle between accesses.
- Requests arriving while the FIFO is full are stalled (req_ready = 0); none are ever dropped.
- busy = (state != IDLE) || (count != 0).

Optional Feature:
MEM_ACCESS_CTRL_WRITE_VERIFY_EN
- With the macro defined: after the ACCESS phase of a write, the FSM goes to VSETUP (1 cycle, mem_op = 0, same address), then VACCESS (ACCESS_CYCLES cycles, mem_select = 1). On the last VACCESS cycle, mem_rdata is compared with the written data. On mismatch, err_verify is set and stays set (sticky) until reset. Then go to DONE, where wr_done pulses. Write latency grows by 1+ACCESS_CYCLES cycles.
- Without the macro: VSETUP and VACCESS do not exist and err_verify is tied to 0.

Test Plan:
- Reset mid-ACCESS of a write to addr 5: assert i_rst_n = 0 -> mem_select drops immediately, all outputs are 0, and after release busy = 0 and req_ready = 1.
- Write 0xA5 to addr 3, then read addr 3 (ACCESS_CYCLES = 2): wr_done pulses at cycle 5, rsp_valid rises at cycle 11 with rsp_rdata = 0xA5, and mem_adr = 3 throughout select-high.
- Push 5 requests back-to-back with FIFO_DEPTH = 4 while the FSM is busy -> req_ready drops after 4 are accepted, the 5th is held until a pop, and all 5 execute in order.
- Read addr 7 with rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_rdata stay stable, no new access starts, and the queued write only executes after the handshake.
- Simultaneous push and pop with count = 2 -> count stays 2 and req_ready stays 1.
- With MEM_ACCESS_CTRL_WRITE_VERIFY_EN defined, a memory model with bit 0 stuck at 0, and a write of 0x01 to addr 2 -> err_verify = 1 and wr_done pulses at cycle 8. Without the macro, the same stimulus gives err_verify = 0 and wr_done at cycle 5.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// mem_access_ctrl: queues host read/write requests and replays each one
// as a SETUP / ACCESS / DONE select pulse on the 8x8 memory pins.
// Host side : req_valid/req_ready/req_we/req_adr/req_wdata in,
//             rsp_valid/rsp_ready/rsp_rdata out, wr_done, busy, err_verify.
// Memory side: mem_adr, mem_wdata, mem_op, mem_select out; mem_rdata in.
// Optional macro MEM_ACCESS_CTRL_WRITE_VERIFY_EN adds a read-back check
// after every write (VSETUP/VACCESS) and drives a sticky err_verify.
module mem_access_ctrl #(
   parameter int FIFO_DEPTH    = 4,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [2:0] req_adr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       wr_done,
   output logic       busy,
   output logic       err_verify,
   output logic [2:0] mem_adr,
   output logic [7:0] mem_wdata,
   output logic       mem_op,
   output logic       mem_select,
   input  logic [7:0] mem_rdata
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CYC_LOAD = CW'(ACCESS_CYCLES - 1);
   localparam logic [CW-1:0] CYC_ONE  = CW'(1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETUP   = 3'd1;
   localparam logic [2:0] S_ACCESS  = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
   localparam logic [2:0] S_VSETUP  = 3'd4;
   localparam logic [2:0] S_VACCESS = 3'd5;
`endif

   // request FIFO
   logic [11:0]   fifo_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ready_en_q;
   logic          full, empty, push, pop;
   logic [11:0]   head;

   // sequencer
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic          cmd_we_q, cmd_we_d;
   logic [2:0]    cmd_adr_q, cmd_adr_d;
   logic [7:0]    cmd_wdata_q, cmd_wdata_d;
   logic [7:0]    rdata_q, rdata_d;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
   logic          err_q, err_d;
`endif

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   // ready_en_q keeps req_ready low while reset is held
   assign req_ready = ready_en_q && !full;
   assign push  = req_valid && req_ready;
   assign pop   = (state_q == S_IDLE) && !empty;
   assign head  = fifo_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (push) fifo_q[wr_ptr_q] <= {req_we, req_adr, req_wdata};
   end

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      cmd_we_d    = cmd_we_q;
      cmd_adr_d   = cmd_adr_q;
      cmd_wdata_d = cmd_wdata_q;
      rdata_d     = rdata_q;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
      err_d       = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               {cmd_we_d, cmd_adr_d, cmd_wdata_d} = head;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            cyc_d   = CYC_LOAD;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (cyc_q == '0) begin
               if (!cmd_we_q) rdata_d = mem_rdata;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
               state_d = cmd_we_q ? S_VSETUP : S_DONE;
`else
               state_d = S_DONE;
`endif
            end else begin
               cyc_d = cyc_q - CYC_ONE;
            end
         end
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
         S_VSETUP: begin
            cyc_d   = CYC_LOAD;
            state_d = S_VACCESS;
         end
         S_VACCESS: begin
            if (cyc_q == '0) begin
               if (mem_rdata != cmd_wdata_q) err_d = 1'b1;
               state_d = S_DONE;
            end else begin
               cyc_d = cyc_q - CYC_ONE;
            end
         end
`endif
         S_DONE: begin
            // reads wait here for the host handshake
            if (cmd_we_q || rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ready_en_q  <= 1'b0;
         state_q     <= S_IDLE;
         cyc_q       <= '0;
         cmd_we_q    <= 1'b0;
         cmd_adr_q   <= '0;
         cmd_wdata_q <= '0;
         rdata_q     <= '0;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
         err_q       <= 1'b0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ready_en_q  <= 1'b1;
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         cmd_we_q    <= cmd_we_d;
         cmd_adr_q   <= cmd_adr_d;
         cmd_wdata_q <= cmd_wdata_d;
         rdata_q     <= rdata_d;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
         err_q       <= err_d;
`endif
      end
   end

   // pin decode straight from the reset flops: select drops with reset
   assign mem_adr   = cmd_adr_q;
   assign mem_wdata = cmd_wdata_q;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
   assign mem_select = (state_q == S_ACCESS) || (state_q == S_VACCESS);
   assign err_verify = err_q;
`else
   assign mem_select = (state_q == S_ACCESS);
   assign err_verify = 1'b0;
`endif
   assign mem_op    = cmd_we_q &&
                      ((state_q == S_SETUP) || (state_q == S_ACCESS));
   assign rsp_valid = (state_q == S_DONE) && !cmd_we_q;
   assign rsp_rdata = rdata_q;
   assign wr_done   = (state_q == S_DONE) && cmd_we_q;
   assign busy      = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// tb_mem_access_ctrl: directed vectors plus hand sequences for reset,
// FIFO backpressure, response stall and write-verify.
module tb_mem_access_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [2:0] req_adr = '0;
   logic [7:0] req_wdata = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_rdata;
   logic       wr_done;
   logic       busy;
   logic       err_verify;
   logic [2:0] mem_adr;
   logic [7:0] mem_wdata;
   logic       mem_op;
   logic       mem_select;
   logic [7:0] mem_rdata;

`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
   localparam int   WLAT    = 8;
   localparam logic EXP_ERR = 1'b1;
`else
   localparam int   WLAT    = 5;
   localparam logic EXP_ERR = 1'b0;
`endif
   localparam int RLAT = 5;

   always #5 i_clk = ~i_clk;

   mem_access_ctrl #(.FIFO_DEPTH(4), .ACCESS_CYCLES(2)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_adr(req_adr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .wr_done(wr_done), .busy(busy),
      .err_verify(err_verify), .mem_adr(mem_adr),
      .mem_wdata(mem_wdata), .mem_op(mem_op),
      .mem_select(mem_select), .mem_rdata(mem_rdata)
   );

   // memory model, optional bit-0 stuck-at-0 on read
   logic [7:0] mem [8];
   logic       mem_clr = 1'b1;
   logic       stuck0 = 1'b0;

   always @(posedge i_clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 8; i++) mem[i] <= 8'(i * 17);
      end else if (mem_select && mem_op) begin
         mem[mem_adr] <= mem_wdata;
      end
   end

   always_comb begin
      mem_rdata = 8'h00;
      if (mem_select && !mem_op)
         mem_rdata = mem[mem_adr] & (stuck0 ? 8'hFE : 8'hFF);
   end

   // completion log and address watch
   logic [11:0] done_log [$];
   logic [2:0]  exp_adr = '0;
   int          adr_bad = 0;

   always @(negedge i_clk) begin
      if (mem_select && mem_adr != exp_adr) adr_bad++;
      if (wr_done) done_log.push_back({1'b1, mem_adr, mem_wdata});
      if (rsp_valid && rsp_ready)
         done_log.push_back({1'b0, mem_adr, rsp_rdata});
   end

   int nvec = 0;
   int nfail = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      nvec++;
      nfail++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || !req_ready) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) timeout("wait_idle");
   endtask

   // returns just after the accepting edge (edge 0)
   task automatic push(input logic we, input logic [2:0] adr,
                       input logic [7:0] wd);
      int n = 0;
      req_we = we;
      req_adr = adr;
      req_wdata = wd;
      req_valid = 1'b1;
      while (!req_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) timeout("push");
      tick();
      req_valid = 1'b0;
   endtask

   // cycle k is the period between edge k-1 and edge k
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!(wr_done || rsp_valid) && cyc < 60) begin
         tick();
         cyc++;
      end
   endtask

   function automatic logic [31:0] outs();
      return {12'd0, req_ready, rsp_valid, rsp_rdata, wr_done, busy,
              err_verify, mem_adr, mem_wdata, mem_op, mem_select};
   endfunction

   typedef struct {
      logic       we;
      logic [2:0] adr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;

   vec_t tv [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c, c2, base, lb, n, bad;
      logic [7:0] hold_d;
      logic [11:0] exp_log [6];

      tv[0] = '{1'b1, 3'd0, 8'h3C, 8'h00};
      tv[1] = '{1'b0, 3'd6, 8'h00, 8'h66};
      tv[2] = '{1'b1, 3'd7, 8'hFF, 8'h00};
      tv[3] = '{1'b0, 3'd0, 8'h00, 8'h3C};
      tv[4] = '{1'b0, 3'd7, 8'h00, 8'hFF};
      tv[5] = '{1'b0, 3'd3, 8'h00, 8'hA5};
      tv[6] = '{1'b1, 3'd7, 8'hC3, 8'h00};
      tv[7] = '{1'b0, 3'd7, 8'h00, 8'hC3};

      // reset state
      #2;
      check("reset_outs", outs(), 32'd0);
      #10 i_rst_n = 1'b1;
      @(posedge i_clk);
      mem_clr = 1'b0;
      #1;
      check("rel_ready", req_ready, 1'b1);
      check("rel_busy", busy, 1'b0);

      // write A5 @3 then read @3 as soon as the FSM is idle
      exp_adr = 3'd3;
      base = adr_bad;
      push(1'b1, 3'd3, 8'hA5);
      wait_done(c);
      check("a_wr_cycle", c, WLAT);
      tick();
      check("a_wr_pulse", wr_done, 1'b0);
      push(1'b0, 3'd3, 8'h00);
      wait_done(c2);
      check("a_rd_cycle", WLAT + 1 + c2, WLAT + 6);
      check("a_rd_valid", rsp_valid, 1'b1);
      check("a_rd_data", rsp_rdata, 8'hA5);
      check("a_adr_sel", adr_bad - base, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("a_rsp_clr", rsp_valid, 1'b0);

      // reset in the middle of a write access
      wait_idle();
      exp_adr = 3'd5;
      push(1'b1, 3'd5, 8'h5A);
      n = 0;
      while (!mem_select && n < 10) begin
         tick();
         n++;
      end
      check("mr_in_access", mem_select, 1'b1);
      #3 i_rst_n = 1'b0;
      #1;
      check("mr_select", mem_select, 1'b0);
      check("mr_outs", outs(), 32'd0);
      #2 i_rst_n = 1'b1;
      tick();
      check("mr_busy", busy, 1'b0);
      check("mr_ready", req_ready, 1'b1);
      check("mr_count", dut.count_q, 0);

      // table of single transactions
      for (int i = 0; i < 8; i++) begin
         wait_idle();
         exp_adr = tv[i].adr;
         base = adr_bad;
         push(tv[i].we, tv[i].adr, tv[i].wdata);
         wait_done(c);
         check($sformatf("v%0d_lat", i), c, tv[i].we ? WLAT : RLAT);
         check($sformatf("v%0d_adr", i), adr_bad - base, 0);
         if (tv[i].we) begin
            tick();
            check($sformatf("v%0d_pulse", i), wr_done, 1'b0);
         end else begin
            check($sformatf("v%0d_data", i), rsp_rdata, tv[i].exp);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check($sformatf("v%0d_clr", i), rsp_valid, 1'b0);
         end
      end

      // stalled read @7 while 5 requests queue behind it
      wait_idle();
      push(1'b0, 3'd7, 8'h00);
      wait_done(c);
      check("s_rd_valid", rsp_valid, 1'b1);
      check("s_rd_data", rsp_rdata, 8'hC3);
      hold_d = rsp_rdata;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_we = (i < 2);
         req_adr = 3'(i % 2 + 1);
         req_wdata = (i == 0) ? 8'h11 : 8'h22;
         if (!req_ready) bad++;
         tick();
         if (!rsp_valid || rsp_rdata != hold_d || mem_select) bad++;
      end
      req_we = 1'b1;
      req_adr = 3'd4;
      req_wdata = 8'h44;
      check("s_full_ready", req_ready, 1'b0);
      check("s_full_count", dut.count_q, 4);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (!rsp_valid || rsp_rdata != hold_d || mem_select) bad++;
         if (req_ready) bad++;
      end
      check("s_stall_stable", bad, 0);
      check("s_count_held", dut.count_q, 4);
      lb = done_log.size();
      rsp_ready = 1'b1;
      tick();
      n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      tick();
      req_valid = 1'b0;
      wait_idle();
      rsp_ready = 1'b0;
      exp_log[0] = {1'b0, 3'd7, 8'hC3};
      exp_log[1] = {1'b1, 3'd1, 8'h11};
      exp_log[2] = {1'b1, 3'd2, 8'h22};
      exp_log[3] = {1'b0, 3'd1, 8'h11};
      exp_log[4] = {1'b0, 3'd2, 8'h22};
      exp_log[5] = {1'b1, 3'd4, 8'h44};
      check("s_log_len", done_log.size() - lb, 6);
      for (int i = 0; i < 6; i++) begin
         if (lb + i < done_log.size())
            check($sformatf("s_order%0d", i), done_log[lb + i],
                  exp_log[i]);
      end

      // push and pop on the same edge with two entries queued
      wait_idle();
      push(1'b0, 3'd0, 8'h00);
      wait_done(c);
      push(1'b1, 3'd5, 8'h77);
      push(1'b1, 3'd6, 8'h88);
      check("pp_count_pre", dut.count_q, 2);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      req_we = 1'b1;
      req_adr = 3'd3;
      req_wdata = 8'h99;
      req_valid = 1'b1;
      check("pp_ready_pre", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      check("pp_count", dut.count_q, 2);
      check("pp_ready", req_ready, 1'b1);
      check("pp_popped", busy, 1'b1);
      wait_idle();

      // write-verify against a bit-0 stuck-at-0 memory
      check("wv_err_pre", err_verify, 1'b0);
      stuck0 = 1'b1;
      push(1'b1, 3'd2, 8'h01);
      wait_done(c);
      check("wv_cycle", c, WLAT);
      check("wv_err", err_verify, EXP_ERR);
      tick();
      stuck0 = 1'b0;
      push(1'b1, 3'd2, 8'h02);
      wait_done(c);
      check("wv_sticky", err_verify, EXP_ERR);
      wait_idle();

      // reset clears everything, including the sticky error
      #3 i_rst_n = 1'b0;
      #1;
      check("end_reset_outs", outs(), 32'd0);
      #3 i_rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
